debounce_array: RTL and testbench

- Parametrised multi-channel push-button conditioner for the Basys3 RTC front panel, in the clk_in domain.
- Generalises the single-button debouncer to N_CH independent channels.
- Per channel: debounced level, one-cycle press pulse, one-cycle release pulse, and an optional auto-repeat pulse train while a button is held, used for fast time-setting.
- Sits between the raw btn pins and the RTC set/mode controller.

---
 rtl/debounce_array.sv | 145 ++++++++++++++
 tb/tb_debounce_array.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/debounce_array.sv
// Multi-channel push-button conditioner: 2-flop sync, debounce, press/release pulses.
// Auto-repeat pulse train while held is built only when DEBOUNCE_AUTO_REPEAT_EN is defined.
module debounce_array #(
  parameter int unsigned N_CH            = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 100_000_000,
  parameter int unsigned REPEAT_CYCLES   = 20_000_000
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pb,
  output logic [N_CH-1:0] pb_level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0] sync0;
  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] stable;
  logic [DW-1:0]   db_cnt [N_CH];
  logic [N_CH-1:0] db_done;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;

  // Debounce terminal: input has differed from stable for DEBOUNCE_CYCLES samples
  always_comb begin
    db_done = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      db_done[i] = (sync1[i] != stable[i]) && (db_cnt[i] == DB_LAST);
    end
    rise = db_done & sync1;
    fall = db_done & ~sync1;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync0         <= '0;
      sync1         <= '0;
      stable        <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync0         <= pb;
      sync1         <= sync0;
      stable        <= stable ^ db_done;
      press_pulse   <= rise;
      release_pulse <= fall;
      for (int i = 0; i < int'(N_CH); i++) begin
        if ((sync1[i] == stable[i]) || db_done[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign pb_level = stable;

`ifdef DEBOUNCE_AUTO_REPEAT_EN
  localparam int unsigned HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HW     = $clog2(HR_MAX + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_REPEAT  = 2'd2
  } state_e;

  state_e          state_q  [N_CH];
  state_e          state_d  [N_CH];
  logic [HW-1:0]   hr_cnt_q [N_CH];
  logic [HW-1:0]   hr_cnt_d [N_CH];
  logic [N_CH-1:0] rep_d;

  // State register, hold/repeat counters and registered repeat pulse
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      repeat_pulse <= '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        state_q[i]  <= ST_IDLE;
        hr_cnt_q[i] <= '0;
      end
    end else begin
      repeat_pulse <= rep_d;
      for (int i = 0; i < int'(N_CH); i++) begin
        state_q[i]  <= state_d[i];
        hr_cnt_q[i] <= hr_cnt_d[i];
      end
    end
  end

  // Next state; a release always wins over a repeat due in the same cycle
  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      state_d[i]  = state_q[i];
      hr_cnt_d[i] = '0;
      case (state_q[i])
        ST_IDLE: begin
          if (rise[i]) state_d[i] = ST_PRESSED;
        end
        ST_PRESSED: begin
          if (fall[i]) begin
            state_d[i] = ST_IDLE;
          end else if (hr_cnt_q[i] == HOLD_LAST) begin
            state_d[i] = ST_REPEAT;
          end else begin
            hr_cnt_d[i] = hr_cnt_q[i] + HW'(1);
          end
        end
        ST_REPEAT: begin
          if (fall[i]) begin
            state_d[i] = ST_IDLE;
          end else if (hr_cnt_q[i] != REP_LAST) begin
            hr_cnt_d[i] = hr_cnt_q[i] + HW'(1);
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  // Repeat pulse request
  always_comb begin
    rep_d = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      rep_d[i] = !fall[i] &&
                 (((state_q[i] == ST_PRESSED) && (hr_cnt_q[i] == HOLD_LAST)) ||
                  ((state_q[i] == ST_REPEAT)  && (hr_cnt_q[i] == REP_LAST)));
    end
  end
`else
  assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_debounce_array.sv
// Directed bench for debounce_array (DEBOUNCE=8, HOLD=20, REPEAT=5, 5 channels).
module tb_debounce_array;

  localparam int unsigned N_CH = 5;

`ifdef DEBOUNCE_AUTO_REPEAT_EN
  localparam logic [4:0] REP_CH2   = 5'b00100;
  localparam int         REP_TOTAL = 8;
`else
  localparam logic [4:0] REP_CH2   = 5'b00000;
  localparam int         REP_TOTAL = 0;
`endif

  logic            clk_in;
  logic            rst_n;
  logic [N_CH-1:0] pb;
  logic [N_CH-1:0] pb_level;
  logic [N_CH-1:0] press_pulse;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] repeat_pulse;

  int checks;
  int errors;
  int press_n [N_CH];
  int rel_n   [N_CH];
  int rep_n   [N_CH];

  debounce_array #(
    .N_CH           (N_CH),
    .DEBOUNCE_CYCLES(8),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (5)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .pb           (pb),
    .pb_level     (pb_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic clr();
    for (int i = 0; i < int'(N_CH); i++) begin
      press_n[i] = 0;
      rel_n[i]   = 0;
      rep_n[i]   = 0;
    end
  endtask

  // Advance past n active edges, sampling 1 ns after each and tallying pulses
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_in);
      #1;
      for (int i = 0; i < int'(N_CH); i++) begin
        press_n[i] += int'(press_pulse[i]);
        rel_n[i]   += int'(release_pulse[i]);
        rep_n[i]   += int'(repeat_pulse[i]);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    pb     = '0;
    clr();
    tick(3);
    chk("reset_level",   32'(pb_level),      32'h0);
    chk("reset_press",   32'(press_pulse),   32'h0);
    chk("reset_release", 32'(release_pulse), 32'h0);
    chk("reset_repeat",  32'(repeat_pulse),  32'h0);
    rst_n = 1'b1;
    tick(2);

    // Clean press and release on channel 0
    pb[0] = 1'b1;
    tick(9);
    chk("s1_level_early", 32'(pb_level),    32'h0);
    chk("s1_press_early", 32'(press_pulse), 32'h0);
    tick(1);
    chk("s1_level",       32'(pb_level),    32'h01);
    chk("s1_press",       32'(press_pulse), 32'h01);
    tick(1);
    chk("s1_press_one",   32'(press_pulse), 32'h0);
    pb[0] = 1'b0;
    tick(9);
    chk("s1_rel_early",   32'(release_pulse), 32'h0);
    tick(1);
    chk("s1_release",     32'(release_pulse), 32'h01);
    chk("s1_level_low",   32'(pb_level),      32'h0);

    // Bounce on channel 1: 3 high / 2 low for 40 cycles, then settle high
    clr();
    for (int p = 0; p < 8; p++) begin
      pb[1] = 1'b1;
      tick(3);
      pb[1] = 1'b0;
      tick(2);
    end
    chk("s2_no_press", 32'(press_n[1]), 32'd0);
    chk("s2_no_level", 32'(pb_level),   32'h0);
    pb[1] = 1'b1;
    tick(9);
    chk("s2_press_early", 32'(press_pulse), 32'h0);
    tick(1);
    chk("s2_press",       32'(press_pulse), 32'h02);
    tick(1);
    chk("s2_press_count", 32'(press_n[1]),  32'd1);
    pb[1] = 1'b0;
    tick(12);
    chk("s2_release_count", 32'(rel_n[1]), 32'd1);

    // Hold channel 2; release lands exactly when the 9th repeat would be due
    pb[2] = 1'b1;
    tick(10);
    chk("s3_press", 32'(press_pulse), 32'h04);
    clr();
    tick(19);
    chk("s3_no_rep_19", 32'(repeat_pulse), 32'h0);
    tick(1);
    chk("s3_rep_20",    32'(repeat_pulse), 32'(REP_CH2));
    tick(4);
    chk("s3_no_rep_24", 32'(repeat_pulse), 32'h0);
    tick(1);
    chk("s3_rep_25",    32'(repeat_pulse), 32'(REP_CH2));
    tick(25);
    pb[2] = 1'b0;
    tick(9);
    chk("s3_rep_count_59", 32'(rep_n[2]),       32'(REP_TOTAL));
    chk("s3_level_59",     32'(pb_level),       32'h04);
    tick(1);
    chk("s3_release",      32'(release_pulse),  32'h04);
    chk("s3_no_rep_60",    32'(repeat_pulse),   32'h0);
    chk("s3_level_60",     32'(pb_level),       32'h0);
    tick(30);
    chk("s3_rep_count_end", 32'(rep_n[2]),   32'(REP_TOTAL));
    chk("s3_rel_count",     32'(rel_n[2]),   32'd1);
    chk("s3_press_count",   32'(press_n[2]), 32'd0);

    // Simultaneous press on channels 3 and 4, staggered releases
    pb[3] = 1'b1;
    pb[4] = 1'b1;
    tick(10);
    chk("s4_press_both", 32'(press_pulse), 32'h18);
    tick(1);
    pb[3] = 1'b0;
    tick(3);
    pb[4] = 1'b0;
    tick(7);
    chk("s4_release3", 32'(release_pulse), 32'h08);
    tick(3);
    chk("s4_release4", 32'(release_pulse), 32'h10);

    // Reset while channel 0 is repeating, button kept held
    pb[0] = 1'b1;
    tick(10);
    chk("s5_press", 32'(press_pulse), 32'h01);
    tick(25);
    rst_n = 1'b0;
    tick(1);
    chk("s5_rst_level",   32'(pb_level),      32'h0);
    chk("s5_rst_press",   32'(press_pulse),   32'h0);
    chk("s5_rst_release", 32'(release_pulse), 32'h0);
    chk("s5_rst_repeat",  32'(repeat_pulse),  32'h0);
    tick(1);
    rst_n = 1'b1;
    clr();
    tick(9);
    chk("s5_press_early", 32'(press_pulse), 32'h0);
    tick(1);
    chk("s5_repress",     32'(press_pulse), 32'h01);
    chk("s5_level",       32'(pb_level),    32'h01);
    chk("s5_no_release",  32'(rel_n[0]),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
